rs_age_sel: RTL
===============

Name: rs_age_sel

Overview:
- Parametrised reservation station feeding one ALU.
- Accepts issued ops with operands that are either values or ROB tags, and wakes tags from NCDB result buses, including same-cycle issue bypass.
- Dispatches the oldest ready entry through a valid/ready output register.
- Supports full flush on branch mispredict.
- Sits between issue/decode and the ALU.

Parameters:
DEPTH, 16, number of entries (2..32)
XLEN, 32, operand/result width
OP_W, 6, opcode width
ROB_W, 4, ROB tag width (ROB_W <= XLEN)
NCDB, 2, number of CDB broadcast ports (1..4)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
rdy  in  1  global enable; low freezes all state except rst/flush
flush  in  1  mispredict flush
is_valid  in  1  issue request
is_opcode  in  OP_W  opcode
is_rs1_val  in  XLEN  operand 1 value, or ROB tag in bits [ROB_W-1:0] when not ready
is_rs1_rdy  in  1  operand 1 holds a value
is_rs2_val  in  XLEN  operand 2 value/tag
is_rs2_rdy  in  1  operand 2 holds a value
is_rob  in  ROB_W  destination ROB tag
full  out  1  no free entry
count  out  $clog2(DEPTH+1)  occupied entries
cdb_valid  in  NCDB  per-port broadcast valid
cdb_rob  in  NCDB*ROB_W  per-port tag, port k at [k*ROB_W +: ROB_W]
cdb_val  in  NCDB*XLEN  per-port result
alu_valid  out  1  output holds an op
alu_ready  in  1  ALU accepts
alu_opcode  out  OP_W  opcode
alu_lhs  out  XLEN  operand 1
alu_rhs  out  XLEN  operand 2
alu_rob  out  ROB_W  destination tag

Behaviour:
- Priority: rst > flush > rdy low (hold) > normal.
- rst: all busy/rdy bits 0, alu_valid=0, count=0, full=0, age state cleared. Data outputs reset to 0.
- flush (any rdy): next cycle all entries free, alu_valid=0, count=0. Same-cycle issue, dispatch and wakeup are discarded.
- full = (count == DEPTH), combinational from registered count.
- Issue:
  - Accepted iff is_valid && !full; ignored otherwise, with no side effects.
  - Written into the lowest-index free slot and becomes youngest in the age order.
  - Per operand: if !rdy and some cdb_valid[k] has cdb_rob[k] == tag this cycle, store cdb_val[k] with rdy=1 (issue bypass). Lowest k wins.
- Wakeup: each cycle, every busy entry with operand not ready and low ROB_W bits == a valid CDB tag captures that value and sets rdy. Lowest k wins on multiple matches. Ports are fully independent.
- Eligibility: busy && rdy1 && rdy2 as registered at the start of the cycle.
  - Newly issued and newly woken entries are eligible the following cycle; minimum issue-to-alu_valid latency is 2 cycles with ready operands.
- Select: oldest eligible entry, by age matrix or equivalent true issue order, not by index.
- Output register:
  - Load when alu_valid==0 or alu_ready==1, and an eligible entry exists.
  - Loading frees that entry in the same edge and sets alu_valid=1.
  - If alu_valid && alu_ready and nothing is eligible, alu_valid goes 0.
  - While alu_valid && !alu_ready, outputs are held stable.
  - Sustains 1 dispatch/cycle.
- count next = count + issue_accepted - dispatch_loaded. Simultaneous issue+dispatch keeps count. When full, issue is refused even if a dispatch frees a slot that cycle.
- A freed slot is reusable by issue in the next cycle, not the same cycle.
- rdy low: no issue, wakeup, dispatch or count change. alu_valid and outputs held. CDB broadcasts during rdy low are lost; upstream guarantees none occur.

Test Plan:
- Reset then issue op=0x05, rs1=10, rs2=20, both ready, rob=3 with alu_ready=1 -> cycle+2: alu_valid=1, lhs=10, rhs=20, alu_rob=3. Next cycle alu_valid=0, count=0.
- Issue A (rob=1, rs1 tag 7 not ready), then B (rob=2, ready). Then cdb port1 tag7 val=0x55 -> B dispatches first. A dispatches with lhs=0x55 the cycle after the wakeup-eligible cycle.
- Age order: issue 3 ops with ready operands and alu_ready=0 into slots 0,1,2. Dispatch slot0 and refill slot0 with D. Raise alu_ready -> order is slot1, slot2, D, not D first.
- Fill DEPTH entries with unready operands -> full=1, count=DEPTH; further is_valid ignored. Broadcast tag on cdb port0 and port1 simultaneously for two different tags -> both entries wake, full drops after their dispatch.
- Issue with rs2 tag 4 while cdb port0 broadcasts tag4 val=0x99 same cycle -> entry dispatches with rhs=0x99 and no further broadcast needed.
- With 5 entries busy and alu_valid=1 stalled (alu_ready=0), assert flush together with is_valid -> next cycle count=0, alu_valid=0, full=0, and the issued op is absent.

Source files
------------

// File: rtl/rs_age_sel_if.sv
// Issue, CDB broadcast and ALU dispatch bundle for the age-ordered reservation station.
// The slave modport is the station itself; the master modport is its environment.
interface rs_age_sel_if #(
  parameter int DEPTH = 16,
  parameter int XLEN  = 32,
  parameter int OP_W  = 6,
  parameter int ROB_W = 4,
  parameter int NCDB  = 2
);
  localparam int CW = $clog2(DEPTH + 1);

  logic                   is_valid;
  logic [OP_W-1:0]        is_opcode;
  logic [XLEN-1:0]        is_rs1_val;
  logic                   is_rs1_rdy;
  logic [XLEN-1:0]        is_rs2_val;
  logic                   is_rs2_rdy;
  logic [ROB_W-1:0]       is_rob;
  logic                   full;
  logic [CW-1:0]          count;

  logic [NCDB-1:0]        cdb_valid;
  logic [NCDB*ROB_W-1:0]  cdb_rob;
  logic [NCDB*XLEN-1:0]   cdb_val;

  logic                   alu_valid;
  logic                   alu_ready;
  logic [OP_W-1:0]        alu_opcode;
  logic [XLEN-1:0]        alu_lhs;
  logic [XLEN-1:0]        alu_rhs;
  logic [ROB_W-1:0]       alu_rob;

  modport master (
    output is_valid, is_opcode, is_rs1_val, is_rs1_rdy, is_rs2_val, is_rs2_rdy, is_rob,
    output cdb_valid, cdb_rob, cdb_val,
    output alu_ready,
    input  full, count,
    input  alu_valid, alu_opcode, alu_lhs, alu_rhs, alu_rob
  );

  modport slave (
    input  is_valid, is_opcode, is_rs1_val, is_rs1_rdy, is_rs2_val, is_rs2_rdy, is_rob,
    input  cdb_valid, cdb_rob, cdb_val,
    input  alu_ready,
    output full, count,
    output alu_valid, alu_opcode, alu_lhs, alu_rhs, alu_rob
  );
endinterface

// File: rtl/rs_age_sel.sv
// Reservation station for one ALU: tag wakeup from the CDB ports (with issue bypass),
// oldest-ready selection through an age matrix, and a valid/ready output register.
module rs_age_sel #(
  parameter int DEPTH = 16,
  parameter int XLEN  = 32,
  parameter int OP_W  = 6,
  parameter int ROB_W = 4,
  parameter int NCDB  = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic rdy,
  input  logic flush,
  rs_age_sel_if.slave rs
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Does any valid CDB port carry this tag?
  function automatic logic cdb_hit(
    input logic [ROB_W-1:0]      tag,
    input logic [NCDB-1:0]       vld,
    input logic [NCDB*ROB_W-1:0] tags
  );
    logic h;
    h = 1'b0;
    for (int k = 0; k < NCDB; k++)
      if (vld[k] && (tags[k*ROB_W +: ROB_W] == tag)) h = 1'b1;
    return h;
  endfunction

  // Value from the lowest-numbered matching port (scan downward so port 0 lands last).
  function automatic logic [XLEN-1:0] cdb_pick(
    input logic [ROB_W-1:0]      tag,
    input logic [NCDB-1:0]       vld,
    input logic [NCDB*ROB_W-1:0] tags,
    input logic [NCDB*XLEN-1:0]  vals
  );
    logic [XLEN-1:0] v;
    v = '0;
    for (int k = NCDB - 1; k >= 0; k--)
      if (vld[k] && (tags[k*ROB_W +: ROB_W] == tag)) v = vals[k*XLEN +: XLEN];
    return v;
  endfunction

  // Entry state: control bits are reset, payload is not.
  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] r1;
  logic [DEPTH-1:0] r2;
  logic [DEPTH-1:0] older [DEPTH];   // older[j][i]: entry j was issued before entry i
  logic [OP_W-1:0]  op    [DEPTH];
  logic [XLEN-1:0]  v1    [DEPTH];
  logic [XLEN-1:0]  v2    [DEPTH];
  logic [ROB_W-1:0] rob   [DEPTH];
  logic [CW-1:0]    count;

  logic             alu_vld_p1;
  logic [OP_W-1:0]  alu_op_p1;
  logic [XLEN-1:0]  alu_lhs_p1;
  logic [XLEN-1:0]  alu_rhs_p1;
  logic [ROB_W-1:0] alu_rob_p1;

  logic             full;
  logic             issue_acc;
  logic             disp_load;
  logic             any_elig;
  logic [IW-1:0]    free_idx;
  logic [IW-1:0]    sel_idx;
  logic [DEPTH-1:0] elig;
  logic [DEPTH-1:0] oldest;
  logic [DEPTH-1:0] wk1;
  logic [DEPTH-1:0] wk2;
  logic [XLEN-1:0]  wv1 [DEPTH];
  logic [XLEN-1:0]  wv2 [DEPTH];
  logic             byp1;
  logic             byp2;
  logic [XLEN-1:0]  is1_val;
  logic [XLEN-1:0]  is2_val;

  assign full      = (count == CW'(DEPTH));
  assign issue_acc = rs.is_valid && !full;
  assign elig      = busy & r1 & r2;
  assign any_elig  = |elig;
  assign disp_load = any_elig && (!alu_vld_p1 || rs.alu_ready);

  // ---- stage p0: issue slot, bypass and wakeup matching ----
  always_comb begin
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--)
      if (!busy[i]) free_idx = IW'(i);
  end

  always_comb begin
    byp1    = !rs.is_rs1_rdy && cdb_hit(rs.is_rs1_val[ROB_W-1:0], rs.cdb_valid, rs.cdb_rob);
    byp2    = !rs.is_rs2_rdy && cdb_hit(rs.is_rs2_val[ROB_W-1:0], rs.cdb_valid, rs.cdb_rob);
    is1_val = byp1 ? cdb_pick(rs.is_rs1_val[ROB_W-1:0], rs.cdb_valid, rs.cdb_rob, rs.cdb_val)
                   : rs.is_rs1_val;
    is2_val = byp2 ? cdb_pick(rs.is_rs2_val[ROB_W-1:0], rs.cdb_valid, rs.cdb_rob, rs.cdb_val)
                   : rs.is_rs2_val;
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      wk1[i] = busy[i] && !r1[i] && cdb_hit(v1[i][ROB_W-1:0], rs.cdb_valid, rs.cdb_rob);
      wk2[i] = busy[i] && !r2[i] && cdb_hit(v2[i][ROB_W-1:0], rs.cdb_valid, rs.cdb_rob);
      wv1[i] = cdb_pick(v1[i][ROB_W-1:0], rs.cdb_valid, rs.cdb_rob, rs.cdb_val);
      wv2[i] = cdb_pick(v2[i][ROB_W-1:0], rs.cdb_valid, rs.cdb_rob, rs.cdb_val);
    end
  end

  // An eligible entry is oldest when no other eligible entry predates it.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      oldest[i] = elig[i];
      for (int j = 0; j < DEPTH; j++)
        if (elig[j] && older[j][i]) oldest[i] = 1'b0;
    end
  end

  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < DEPTH; i++)
      if (oldest[i]) sel_idx = IW'(i);
  end

  // ---- stage p1: entry control, age matrix and output register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      busy       <= '0;
      r1         <= '0;
      r2         <= '0;
      count      <= '0;
      alu_vld_p1 <= 1'b0;
      alu_op_p1  <= '0;
      alu_lhs_p1 <= '0;
      alu_rhs_p1 <= '0;
      alu_rob_p1 <= '0;
      for (int i = 0; i < DEPTH; i++) older[i] <= '0;
    end else if (flush) begin
      busy       <= '0;
      count      <= '0;
      alu_vld_p1 <= 1'b0;
    end else if (rdy) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wk1[i]) r1[i] <= 1'b1;
        if (wk2[i]) r2[i] <= 1'b1;
      end
      if (disp_load) begin
        busy[sel_idx] <= 1'b0;
        alu_vld_p1    <= 1'b1;
        alu_op_p1     <= op[sel_idx];
        alu_lhs_p1    <= v1[sel_idx];
        alu_rhs_p1    <= v2[sel_idx];
        alu_rob_p1    <= rob[sel_idx];
      end else if (alu_vld_p1 && rs.alu_ready) begin
        alu_vld_p1 <= 1'b0;
      end
      if (issue_acc) begin
        busy[free_idx]  <= 1'b1;
        r1[free_idx]    <= rs.is_rs1_rdy || byp1;
        r2[free_idx]    <= rs.is_rs2_rdy || byp2;
        older[free_idx] <= '0;
        for (int j = 0; j < DEPTH; j++)
          if (j != int'(free_idx)) older[j][free_idx] <= 1'b1;
      end
      count <= count + CW'(issue_acc) - CW'(disp_load);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush && rdy) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wk1[i]) v1[i] <= wv1[i];
        if (wk2[i]) v2[i] <= wv2[i];
      end
      if (issue_acc) begin
        op[free_idx]  <= rs.is_opcode;
        v1[free_idx]  <= is1_val;
        v2[free_idx]  <= is2_val;
        rob[free_idx] <= rs.is_rob;
      end
    end
  end

  assign rs.full       = full;
  assign rs.count      = count;
  assign rs.alu_valid  = alu_vld_p1;
  assign rs.alu_opcode = alu_op_p1;
  assign rs.alu_lhs    = alu_lhs_p1;
  assign rs.alu_rhs    = alu_rhs_p1;
  assign rs.alu_rob    = alu_rob_p1;
endmodule
